// File: rtl/dm_cache_ctrl_pkg.sv
// Shared definitions for the direct-mapped cache controller.
// Holds the FSM state encoding, the fixed line geometry (32-bit words,
// 128-bit lines, word 0 in the MSBs) and the word select/insert helpers
// used by the controller and its storage array.
package dm_cache_ctrl_pkg;

  localparam int DATA_W     = 32;
  localparam int LINE_W     = 128;
  localparam int WORDS      = LINE_W / DATA_W;
  localparam int OFFSET_W   = 4;   // byte offset inside a line
  localparam int BYTE_OFF_W = 2;   // byte offset inside a word (ignored)
  localparam int WSEL_W     = 2;   // word select inside a line

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    COMPARE    = 2'd1,
    WRITE_BACK = 2'd2,
    ALLOCATE   = 2'd3
  } state_t;

  // Word w lives at bits [LINE_W-1-DATA_W*w -: DATA_W] (word 0 = MSBs).
  function automatic logic [DATA_W-1:0] word_sel(input logic [LINE_W-1:0] line,
                                                 input logic [WSEL_W-1:0] w);
    logic [DATA_W-1:0] r;
    r = '0;
    for (int i = 0; i < WORDS; i++) begin
      if (w == WSEL_W'(i)) r = line[LINE_W-1-DATA_W*i -: DATA_W];
    end
    return r;
  endfunction

  function automatic logic [LINE_W-1:0] word_ins(input logic [LINE_W-1:0] line,
                                                 input logic [WSEL_W-1:0] w,
                                                 input logic [DATA_W-1:0] word);
    logic [LINE_W-1:0] r;
    r = line;
    for (int i = 0; i < WORDS; i++) begin
      if (w == WSEL_W'(i)) r[LINE_W-1-DATA_W*i -: DATA_W] = word;
    end
    return r;
  endfunction

endpackage

// File: rtl/dm_cache_ctrl_if.sv
// Bus bundle between the CPU/memory environment and the cache controller.
//   cpu_req/cpu_we/cpu_addr/cpu_wdata : CPU request, held until cpu_ready
//   cpu_rdata/cpu_ready               : load data and one-cycle completion
//   mem_read/mem_lock/mem_addr        : memory control (mem_lock=1 -> idle)
//   mem_wdata/mem_rdata               : 128-bit victim / fetched block
// Modports: master = environment (CPU + memory), slave = cache controller.
interface dm_cache_ctrl_if #(
  parameter int ADDR_W = 10
);
  import dm_cache_ctrl_pkg::*;

  logic                cpu_req;
  logic                cpu_we;
  logic [ADDR_W-1:0]   cpu_addr;
  logic [DATA_W-1:0]   cpu_wdata;
  logic [DATA_W-1:0]   cpu_rdata;
  logic                cpu_ready;
  logic                mem_read;
  logic                mem_lock;
  logic [ADDR_W-1:0]   mem_addr;
  logic [LINE_W-1:0]   mem_wdata;
  logic [LINE_W-1:0]   mem_rdata;

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata,
    input  cpu_rdata, cpu_ready, mem_read, mem_lock, mem_addr, mem_wdata
  );

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata,
    output cpu_rdata, cpu_ready, mem_read, mem_lock, mem_addr, mem_wdata
  );

endinterface

// File: rtl/dm_cache_ctrl_array.sv
// Tag/valid/dirty/data storage for the direct-mapped cache.
//   clk, rst_n    : clock, async active-low reset (clears valid and dirty)
//   idx_i         : line index, read asynchronously
//   valid_o/dirty_o/tag_o/line_o : state of the indexed line
//   fill_i, fill_tag_i, fill_line_i : whole-line write (valid=1, dirty=0)
//   word_we_i, word_sel_i, word_i   : single-word store (dirty=1)
module dm_cache_ctrl_array
  import dm_cache_ctrl_pkg::*;
#(
  parameter int NUM_BLOCKS = 4,
  parameter int TAG_W      = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [$clog2(NUM_BLOCKS)-1:0] idx_i,
  output logic                          valid_o,
  output logic                          dirty_o,
  output logic [TAG_W-1:0]              tag_o,
  output logic [LINE_W-1:0]             line_o,
  input  logic                          fill_i,
  input  logic [TAG_W-1:0]              fill_tag_i,
  input  logic [LINE_W-1:0]             fill_line_i,
  input  logic                          word_we_i,
  input  logic [WSEL_W-1:0]             word_sel_i,
  input  logic [DATA_W-1:0]             word_i
);

  logic [NUM_BLOCKS-1:0] valid_q;
  logic [NUM_BLOCKS-1:0] dirty_q;
  logic [TAG_W-1:0]      tag_q  [NUM_BLOCKS];
  logic [LINE_W-1:0]     data_q [NUM_BLOCKS];

  assign valid_o = valid_q[idx_i];
  assign dirty_o = dirty_q[idx_i];
  assign tag_o   = tag_q[idx_i];
  assign line_o  = data_q[idx_i];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (fill_i) begin
      valid_q[idx_i] <= 1'b1;
      dirty_q[idx_i] <= 1'b0;
    end else if (word_we_i) begin
      dirty_q[idx_i] <= 1'b1;
    end
  end

  // Tags and data are meaningless while valid is clear, so they carry no reset.
  always_ff @(posedge clk) begin
    if (fill_i) begin
      tag_q[idx_i]  <= fill_tag_i;
      data_q[idx_i] <= fill_line_i;
    end else if (word_we_i) begin
      data_q[idx_i] <= word_ins(data_q[idx_i], word_sel_i, word_i);
    end
  end

endmodule

// File: rtl/dm_cache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache controller.
// Serves 32-bit CPU loads/stores from a NUM_BLOCKS-line array; on a miss it
// writes back a dirty victim, then fetches the requested 128-bit block, each
// transfer held for MEM_LATENCY cycles on a combinational memory.
//   clk, rst_n : clock, async active-low reset
//   bus        : dm_cache_ctrl_if.slave (CPU request/response, memory port)
module dm_cache_ctrl
  import dm_cache_ctrl_pkg::*;
#(
  parameter int NUM_BLOCKS  = 4,
  parameter int MEM_LATENCY = 4,
  parameter int ADDR_W      = 10
) (
  input logic             clk,
  input logic             rst_n,
  dm_cache_ctrl_if.slave  bus
);

  localparam int INDEX_W = $clog2(NUM_BLOCKS);
  localparam int TAG_W   = ADDR_W - OFFSET_W - INDEX_W;
  localparam int CNT_W   = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

  state_t                    state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic                      live_q, live_d;   // request still wanted by the CPU
  logic [ADDR_W-1:BYTE_OFF_W] addr_q;
  logic                      we_q;
  logic [DATA_W-1:0]         wdata_q;

  logic [TAG_W-1:0]   req_tag;
  logic [INDEX_W-1:0] req_idx;
  logic [WSEL_W-1:0]  req_wsel;
  logic               line_valid, line_dirty;
  logic [TAG_W-1:0]   line_tag;
  logic [LINE_W-1:0]  line_data;
  logic               hit, xfer_last, accept;
  logic               fill_en, word_we;
  logic               unused_byte_off;

  assign req_tag  = addr_q[ADDR_W-1 -: TAG_W];
  assign req_idx  = addr_q[OFFSET_W +: INDEX_W];
  assign req_wsel = addr_q[OFFSET_W-1 -: WSEL_W];

  assign hit       = line_valid && (line_tag == req_tag);
  assign xfer_last = (cnt_q == CNT_W'(MEM_LATENCY - 1));
  assign accept    = (state_q == IDLE) && bus.cpu_req;

  assign unused_byte_off = ^bus.cpu_addr[BYTE_OFF_W-1:0];

  dm_cache_ctrl_array #(
    .NUM_BLOCKS (NUM_BLOCKS),
    .TAG_W      (TAG_W)
  ) u_array (
    .clk         (clk),
    .rst_n       (rst_n),
    .idx_i       (req_idx),
    .valid_o     (line_valid),
    .dirty_o     (line_dirty),
    .tag_o       (line_tag),
    .line_o      (line_data),
    .fill_i      (fill_en),
    .fill_tag_i  (req_tag),
    .fill_line_i (bus.mem_rdata),
    .word_we_i   (word_we),
    .word_sel_i  (req_wsel),
    .word_i      (wdata_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      live_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      live_q  <= live_d;
    end
  end

  // Request latches only matter once accepted, so they carry no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      addr_q  <= bus.cpu_addr[ADDR_W-1:BYTE_OFF_W];
      we_q    <= bus.cpu_we;
      wdata_q <= bus.cpu_wdata;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:       if (bus.cpu_req) state_d = COMPARE;
      // An abandoned request (live_q low) still finishes its fill, then exits quietly.
      COMPARE: begin
        if (hit || !live_q)  state_d = IDLE;
        else if (line_dirty) state_d = WRITE_BACK;
        else                 state_d = ALLOCATE;
      end
      WRITE_BACK: if (xfer_last) state_d = ALLOCATE;
      ALLOCATE:   if (xfer_last) state_d = COMPARE;
      default:    state_d = IDLE;
    endcase

    // Counter restarts on every state entry; it only advances during transfers.
    cnt_d = '0;
    if ((state_d == state_q) && ((state_q == WRITE_BACK) || (state_q == ALLOCATE)))
      cnt_d = cnt_q + CNT_W'(1);

    if (state_q == IDLE) live_d = bus.cpu_req;
    else                 live_d = live_q && bus.cpu_req;
  end

  always_comb begin
    bus.cpu_ready = 1'b0;
    bus.cpu_rdata = '0;
    bus.mem_lock  = 1'b1;
    bus.mem_read  = 1'b1;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    fill_en       = 1'b0;
    word_we       = 1'b0;
    case (state_q)
      COMPARE: begin
        if (hit && live_q) begin
          bus.cpu_ready = 1'b1;
          if (we_q) word_we       = 1'b1;
          else      bus.cpu_rdata = word_sel(line_data, req_wsel);
        end
      end
      WRITE_BACK: begin
        bus.mem_lock  = 1'b0;
        bus.mem_read  = 1'b0;
        bus.mem_addr  = {line_tag, req_idx, OFFSET_W'(0)};
        bus.mem_wdata = line_data;
      end
      ALLOCATE: begin
        bus.mem_lock = 1'b0;
        bus.mem_addr = {req_tag, req_idx, OFFSET_W'(0)};
        fill_en      = xfer_last;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dm_cache_ctrl.sv
// Directed bench for dm_cache_ctrl with a combinational 64-block memory.
module tb_dm_cache_ctrl;
  import dm_cache_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dm_cache_ctrl_if #(.ADDR_W(10)) bus();

  dm_cache_ctrl #(
    .NUM_BLOCKS  (4),
    .MEM_LATENCY (4),
    .ADDR_W      (10)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [127:0] mem [64];
  assign bus.mem_rdata = mem[bus.mem_addr[9:4]];
  always @(posedge clk) begin
    if (!bus.mem_lock && !bus.mem_read) mem[bus.mem_addr[9:4]] = bus.mem_wdata;
  end

  int n_checks = 0;
  int n_fail   = 0;

  logic       tr_lock [41];
  logic       tr_read [41];
  logic [9:0] tr_addr [41];
  int         lat;
  logic [31:0] rd;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One CPU access: lat = cycles from acceptance to cpu_ready (0 = timeout).
  task automatic access(input logic we, input logic [9:0] addr, input logic [31:0] wd);
    @(negedge clk);
    bus.cpu_req = 1'b1; bus.cpu_we = we; bus.cpu_addr = addr; bus.cpu_wdata = wd;
    lat = 0; rd = '0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      tr_lock[n] = bus.mem_lock; tr_read[n] = bus.mem_read; tr_addr[n] = bus.mem_addr;
      if (bus.cpu_ready) begin
        lat = n; rd = bus.cpu_rdata;
        break;
      end
    end
    @(posedge clk); #1;
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0;
  endtask

  task automatic check_phase(input string tag, input int from, input int to,
                             input logic lk, input logic rdv, input logic [9:0] ad);
    int bad = 0;
    for (int c = from; c <= to; c++)
      if (tr_lock[c] !== lk || tr_read[c] !== rdv || tr_addr[c] !== ad) bad++;
    check(tag, bad, 0);
  endtask

  initial begin
    int rdy_seen;
    for (int i = 0; i < 64; i++) mem[i] = '0;
    mem[6'h00] = {32'h11111111, 32'h00003CC3, 32'h22222222, 32'h00000003};
    mem[6'h10] = {32'h0, 32'h0000ABCD, 32'h0, 32'h0};
    mem[6'h20] = {32'h0, 32'h00000CCC, 32'h0, 32'h0};
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;

    repeat (2) @(posedge clk); #1;
    check("rst cpu_ready", bus.cpu_ready, 0);
    check("rst cpu_rdata", bus.cpu_rdata, 0);
    check("rst mem_lock",  bus.mem_lock, 1);
    check("rst mem_read",  bus.mem_read, 1);
    check("rst mem_addr",  bus.mem_addr, 0);
    check("rst mem_wdata", bus.mem_wdata, 0);
    @(negedge clk); rst_n = 1'b1;

    access(1'b0, 10'h004, 32'h0);
    check("ld004 lat", lat, 6);
    check("ld004 data", rd, 32'h00003CC3);
    check("ld004 cmp lock", tr_lock[1], 1);
    check_phase("ld004 alloc", 2, 5, 1'b0, 1'b1, 10'h000);

    access(1'b0, 10'h00C, 32'h0);
    check("ld00C lat", lat, 1);
    check("ld00C data", rd, 32'h00000003);
    check("ld00C lock", tr_lock[1], 1);

    access(1'b1, 10'h000, 32'hDEADBEEF);
    check("st000 lat", lat, 1);
    check_phase("st000 quiet", 1, 1, 1'b1, 1'b1, 10'h000);

    access(1'b0, 10'h204, 32'h0);
    check("ld204 lat", lat, 10);
    check("ld204 data", rd, 32'h00000CCC);
    check_phase("ld204 wb", 2, 5, 1'b0, 1'b0, 10'h000);
    check_phase("ld204 alloc", 6, 9, 1'b0, 1'b1, 10'h200);
    check("ld204 mem0", mem[6'h00], {32'hDEADBEEF, 32'h00003CC3, 32'h22222222, 32'h00000003});

    access(1'b0, 10'h300, 32'h0);
    check("ld300 lat", lat, 6);
    check("ld300 data", rd, 32'h0);
    check_phase("ld300 alloc", 2, 5, 1'b0, 1'b1, 10'h300);

    access(1'b0, 10'h000, 32'h0);
    check("ld000 lat", lat, 6);
    check("ld000 data", rd, 32'hDEADBEEF);

    // Reset during the second ALLOCATE cycle of a miss on 0x100.
    @(negedge clk);
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 10'h100;
    repeat (3) @(posedge clk); #1;
    check("alloc2 lock", bus.mem_lock, 0);
    check("alloc2 addr", bus.mem_addr, 10'h100);
    rst_n = 1'b0; #1;
    check("midrst lock", bus.mem_lock, 1);
    check("midrst read", bus.mem_read, 1);
    bus.cpu_req = 1'b0;
    @(negedge clk); rst_n = 1'b1;

    access(1'b0, 10'h00C, 32'h0);
    check("reld00C lat", lat, 6);
    check("reld00C data", rd, 32'h00000003);

    // Request abandoned during ALLOCATE: fill completes, no ready.
    @(negedge clk);
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 10'h104;
    repeat (3) @(posedge clk); #1;
    bus.cpu_req = 1'b0;
    rdy_seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (bus.cpu_ready) rdy_seen++;
    end
    check("drop no ready", rdy_seen, 0);
    access(1'b0, 10'h104, 32'h0);
    check("drop filled lat", lat, 1);
    check("drop filled data", rd, 32'h0000ABCD);

    access(1'b1, 10'h208, 32'h000055AA);
    check("st208 miss lat", lat, 6);
    access(1'b0, 10'h208, 32'h0);
    check("ld208 lat", lat, 1);
    check("ld208 data", rd, 32'h000055AA);

    access(1'b0, 10'h000, 32'h0);
    check("ld000b lat", lat, 10);
    check("ld000b data", rd, 32'hDEADBEEF);
    check_phase("ld000b wb", 2, 5, 1'b0, 1'b0, 10'h200);
    check("ld000b mem20", mem[6'h20], {32'h0, 32'h00000CCC, 32'h000055AA, 32'h0});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
